ascon_perm_arbiter: RTL and testbench
=====================================

// Module: ascon_perm_arbiter
// PURPOSE
//   Shares one Ascon permutation engine between N_REQ requesters (e.g. encrypt and decrypt paths).
//   Round-robin grant, one job in flight, watchdog on the engine's done.
//   Sits between requester datapaths and the permutation core's start/done/state interface.
// PARAMETERS
//   N_REQ     2    number of requesters (2..8)
//   STATE_W   320  permutation state width in bits
//   ROUNDS_A  12   round count for p^a jobs
//   ROUNDS_B  6    round count for p^b jobs
//   TIMEOUT   64   max WAIT cycles before the job is aborted (>= ROUNDS_A*cycles/round + 2)
// PORTS
//   clk           in   1               rising-edge clock
//   reset         in   1               synchronous, active-low reset (asserted when 0)
//   req           in   N_REQ           per-requester job request, level
//   req_rounds_b  in   N_REQ           per-requester: 1 = p^b (ROUNDS_B), 0 = p^a (ROUNDS_A)
//   req_state     in   N_REQ*STATE_W   per-requester input state; slice i = [i*STATE_W +: STATE_W]
//   gnt           out  N_REQ           one-hot grant pulse (1 cycle)
//   rsp_valid     out  N_REQ           one-hot response valid, held until accepted
//   rsp_ready     in   N_REQ           per-requester response accept
//   rsp_state     out  STATE_W         permuted state (shared bus, qualified by rsp_valid)
//   rsp_err       out  1               1 = job aborted by watchdog (qualified by rsp_valid)
//   perm_start    out  1               start pulse to the permutation core
//   perm_nrounds  out  4               round count for the current job
//   perm_in       out  STATE_W         state to the permutation core
//   perm_done     in   1               core completion pulse; perm_out valid in the same cycle
//   perm_out      in   STATE_W         permuted state from the core
//   busy          out  1               1 in every state except IDLE
// BEHAVIOUR
//   Reset (reset==0 at posedge)
//   - state=IDLE, rr_ptr=0, wdog=0.
//   - gnt, rsp_valid, rsp_err, perm_start, busy = 0; perm_nrounds=0; rsp_state=0; perm_in=0.
//   - A reset mid-job abandons the job; no response is produced. perm_done is ignored outside WAIT.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs are registered/Moore.
//   - IDLE: if |req, select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//     Latch idx=i, perm_in=req_state slice i, and perm_nrounds=ROUNDS_B if req_rounds_b[i], else ROUNDS_A.
//     Go to ISSUE.
//   - ISSUE (1 cycle): gnt[idx]=1 and perm_start=1; wdog cleared; go to WAIT.
//   - WAIT: perm_in/perm_nrounds are held stable; wdog += 1 each cycle.
//     - perm_done=1: rsp_state<=perm_out, rsp_err<=0, go to RESP.
//     - else if wdog==TIMEOUT-1: rsp_state<=0, rsp_err<=1, go to RESP.
//     - done and timeout in the same cycle: done wins.
//   - RESP: rsp_valid[idx]=1; rsp_state and rsp_err are stable.
//     When rsp_ready[idx]=1: rsp_valid<=0, rr_ptr<=(idx+1) mod N_REQ, go to IDLE.
//     rsp_ready of other requesters is ignored.
//   Latency
//   - req sampled at cycle t in IDLE -> gnt/perm_start at t+1.
//   - perm_done at cycle d -> rsp_valid at d+1.
//   - rsp_ready at r -> next grant no earlier than r+2.
//   Requester rules
//   - Requester holds req and req_state stable until gnt; it drops req in the cycle after gnt
//     unless it wants another job.
//   - A req raised while busy waits; there is no queueing beyond the level req.
//   Fairness: rr_ptr advances only on completed responses, so each active requester is served
//   within N_REQ jobs.
// TESTING
//   1 Single job: req[0]=1, rounds_b=0, state=IV vector; core model done after 12 cycles
//     -> gnt[0] at t+1, perm_nrounds=12, rsp_valid[0] with model output, rsp_err=0.
//   2 Contention: req=2'b11 from reset -> order 0,1,0,1 over 4 jobs; gnt always one-hot;
//     perm_nrounds follows each requester's rounds_b (12 vs 6).
//   3 Watchdog: core never asserts done, TIMEOUT=64 -> rsp_valid with rsp_err=1 and rsp_state=0
//     exactly 64 cycles after perm_start; a following job completes normally.
//   4 Backpressure: hold rsp_ready[1]=0 for 10 cycles in RESP
//     -> rsp_valid[1]/rsp_state stable, no new gnt, busy=1; release -> IDLE next cycle.
//   5 Reset mid-WAIT: drive reset=0 for 1 cycle, then a late perm_done
//     -> all outputs 0, no rsp_valid, rr_ptr=0; next req[1] granted normally.
//   6 Done on timeout cycle: perm_done at wdog==TIMEOUT-1 -> rsp_err=0 with perm_out captured.

Source files
------------

// File: rtl/ascon_perm_arbiter_if.sv
// Requester and permutation-core signals of the Ascon permutation arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface ascon_perm_arbiter_if #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned STATE_W = 320
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         req_rounds_b;
    logic [N_REQ*STATE_W-1:0] req_state;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [STATE_W-1:0]       rsp_state;
    logic                     rsp_err;
    logic                     perm_start;
    logic [3:0]               perm_nrounds;
    logic [STATE_W-1:0]       perm_in;
    logic                     perm_done;
    logic [STATE_W-1:0]       perm_out;
    logic                     busy;

    modport slave (
        input  req, req_rounds_b, req_state, rsp_ready, perm_done, perm_out,
        output gnt, rsp_valid, rsp_state, rsp_err, perm_start, perm_nrounds, perm_in, busy
    );

    modport master (
        output req, req_rounds_b, req_state, rsp_ready, perm_done, perm_out,
        input  gnt, rsp_valid, rsp_state, rsp_err, perm_start, perm_nrounds, perm_in, busy
    );
endinterface

// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core between N_REQ requesters,
// one job in flight, with a watchdog that aborts a job whose core never reports done.
module ascon_perm_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned STATE_W  = 320,
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic                 clk,
    input logic                 reset,
    ascon_perm_arbiter_if.slave arb_io
);
    localparam int unsigned IdxW  = $clog2(N_REQ);
    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q;
    logic [IdxW-1:0]    idx_q;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [WdogW-1:0]   wdog_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [STATE_W-1:0] rsp_state_q;
    logic               rsp_err_q;
    logic               perm_start_q;
    logic [3:0]         perm_nrounds_q;
    logic [STATE_W-1:0] perm_in_q;

    logic               sel_found;
    logic [IdxW-1:0]    sel_idx;
    logic [IdxW:0]      cand;

    // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(N_REQ)) begin
                cand = cand - (IdxW + 1)'(N_REQ);
            end
            if (!sel_found && arb_io.req[cand[IdxW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            rr_ptr_q       <= '0;
            wdog_q         <= '0;
            gnt_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_state_q    <= '0;
            rsp_err_q      <= 1'b0;
            perm_start_q   <= 1'b0;
            perm_nrounds_q <= '0;
            perm_in_q      <= '0;
        end else begin
            gnt_q        <= '0;
            perm_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        idx_q          <= sel_idx;
                        perm_in_q      <= arb_io.req_state[sel_idx*STATE_W +: STATE_W];
                        perm_nrounds_q <= arb_io.req_rounds_b[sel_idx] ? 4'(ROUNDS_B)
                                                                       : 4'(ROUNDS_A);
                        gnt_q          <= N_REQ'(1) << sel_idx;
                        perm_start_q   <= 1'b1;
                        wdog_q         <= '0;
                        state_q        <= StIssue;
                    end
                end
                StIssue: begin
                    // Watchdog counts from the start pulse so the abort lands TIMEOUT
                    // cycles after perm_start.
                    wdog_q  <= wdog_q + 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (arb_io.perm_done) begin
                        rsp_state_q <= arb_io.perm_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= N_REQ'(1) << idx_q;
                        state_q     <= StResp;
                    end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
                        rsp_state_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= N_REQ'(1) << idx_q;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (arb_io.rsp_ready[idx_q]) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign arb_io.gnt          = gnt_q;
    assign arb_io.rsp_valid    = rsp_valid_q;
    assign arb_io.rsp_state    = rsp_state_q;
    assign arb_io.rsp_err      = rsp_err_q;
    assign arb_io.perm_start   = perm_start_q;
    assign arb_io.perm_nrounds = perm_nrounds_q;
    assign arb_io.perm_in      = perm_in_q;
    assign arb_io.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Directed bench for ascon_perm_arbiter with a behavioural permutation core whose
// completion delay is set per scenario (0 = never completes).
module tb_ascon_perm_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned SW = 320;

    localparam logic [SW-1:0] IV    = 320'h80400c0600000000_000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
    localparam logic [SW-1:0] ST1   = {5{64'hfedcba9876543210}};
    localparam logic [SW-1:0] MASK  = {10{32'h9e3779b9}};

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   model_delay = 0;
    int   model_k = 0;
    bit   model_run = 1'b0;

    ascon_perm_arbiter_if #(.N_REQ(NR), .STATE_W(SW)) arb ();

    ascon_perm_arbiter #(
        .N_REQ(NR), .STATE_W(SW), .ROUNDS_A(12), .ROUNDS_B(6), .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb_io(arb)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] perm_model(input logic [SW-1:0] x);
        return {x[SW-2:0], x[SW-1]} ^ MASK;
    endfunction

    // Core model: done pulses model_delay cycles after the perm_start cycle.
    initial begin
        arb.perm_done = 1'b0;
        arb.perm_out  = '0;
    end
    always @(posedge clk) begin
        arb.perm_done <= 1'b0;
        if (arb.perm_start) begin
            model_k   <= 1;
            model_run <= (model_delay > 1);
            if (model_delay == 1) begin
                arb.perm_done <= 1'b1;
                arb.perm_out  <= perm_model(arb.perm_in);
            end
        end else if (model_run) begin
            model_k <= model_k + 1;
            if (model_k + 1 == model_delay) begin
                arb.perm_done <= 1'b1;
                arb.perm_out  <= perm_model(arb.perm_in);
                model_run     <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (arb.gnt != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (arb.rsp_valid == '0 && cnt < 200);
        if (arb.rsp_valid == '0) cnt = -1;
    endtask

    task automatic ack();
        arb.rsp_ready = arb.rsp_valid;
        tick();
        arb.rsp_ready = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checks++;
        if (arb.gnt !== '0 || arb.rsp_valid !== '0 || arb.perm_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: gnt=%b rsp_valid=%b perm_start=%b, want 0",
                     arb.gnt, arb.rsp_valid, arb.perm_start);
        end
        checks++;
        if (arb.busy !== 1'b0 || arb.rsp_err !== 1'b0 || arb.perm_nrounds !== 4'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b rsp_err=%b nrounds=%0d, want 0",
                     arb.busy, arb.rsp_err, arb.perm_nrounds);
        end
        checks++;
        if (arb.rsp_state !== '0 || arb.perm_in !== '0) begin
            errors++;
            $display("FAIL reset_data: rsp_state=%h perm_in=%h, want 0", arb.rsp_state, arb.perm_in);
        end
    endtask

    task automatic test_single();
        model_delay = 12;
        arb.req_state[0*SW +: SW] = IV;
        arb.req_rounds_b = 2'b00;
        arb.req = 2'b01;
        tick();
        checks++;
        if (arb.gnt !== 2'b01 || arb.perm_start !== 1'b1 || arb.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b start=%b busy=%b, want 01 1 1",
                     arb.gnt, arb.perm_start, arb.busy);
        end
        checks++;
        if (arb.perm_nrounds !== 4'd12 || arb.perm_in !== IV) begin
            errors++;
            $display("FAIL single_issue: nrounds=%0d perm_in=%h, want 12 %h",
                     arb.perm_nrounds, arb.perm_in, IV);
        end
        arb.req = 2'b00;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (arb.rsp_valid !== 2'b00 || arb.gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_early: rsp_valid=%b gnt=%b, want 00 00", arb.rsp_valid, arb.gnt);
        end
        tick();
        checks++;
        if (arb.rsp_valid !== 2'b01 || arb.rsp_err !== 1'b0 || arb.rsp_state !== perm_model(IV)) begin
            errors++;
            $display("FAIL single_rsp: valid=%b err=%b state=%h, want 01 0 %h",
                     arb.rsp_valid, arb.rsp_err, arb.rsp_state, perm_model(IV));
        end
        ack();
        checks++;
        if (arb.rsp_valid !== 2'b00 || arb.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: valid=%b busy=%b, want 00 0", arb.rsp_valid, arb.busy);
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_gnt;
        bit ok;
        int cnt;
        test_reset();
        model_delay = 4;
        arb.req_state = {ST1, IV};
        arb.req_rounds_b = 2'b10;
        arb.req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_gnt = (j % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(ok);
            checks++;
            if (!ok || arb.gnt !== exp_gnt ||
                arb.perm_nrounds !== ((j % 2 == 0) ? 4'd12 : 4'd6)) begin
                errors++;
                $display("FAIL contention_gnt%0d: gnt=%b nrounds=%0d ok=%0d, want %b %0d",
                         j, arb.gnt, arb.perm_nrounds, ok, exp_gnt, (j % 2 == 0) ? 12 : 6);
            end
            wait_rsp(cnt);
            checks++;
            if (cnt != 5 || arb.rsp_valid !== exp_gnt ||
                arb.rsp_state !== perm_model((j % 2 == 0) ? IV : ST1)) begin
                errors++;
                $display("FAIL contention_rsp%0d: cycles=%0d valid=%b state=%h, want 5 %b",
                         j, cnt, arb.rsp_valid, arb.rsp_state, exp_gnt);
            end
            ack();
            checks++;
            if (arb.gnt !== 2'b00 || arb.busy !== 1'b0) begin
                errors++;
                $display("FAIL contention_gap%0d: gnt=%b busy=%b, want 00 0", j, arb.gnt, arb.busy);
            end
        end
        arb.req = 2'b00;
    endtask

    task automatic test_watchdog();
        bit ok;
        int cnt;
        model_delay = 0;
        arb.req_rounds_b = 2'b00;
        arb.req = 2'b01;
        wait_gnt(ok);
        arb.req = 2'b00;
        for (int i = 0; i < 63; i++) tick();
        checks++;
        if (!ok || arb.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL wdog_early: ok=%0d rsp_valid=%b, want 1 00", ok, arb.rsp_valid);
        end
        tick();
        checks++;
        if (arb.rsp_valid !== 2'b01 || arb.rsp_err !== 1'b1 || arb.rsp_state !== '0) begin
            errors++;
            $display("FAIL wdog_abort: valid=%b err=%b state=%h, want 01 1 0",
                     arb.rsp_valid, arb.rsp_err, arb.rsp_state);
        end
        ack();
        model_delay = 5;
        arb.req = 2'b01;
        wait_gnt(ok);
        arb.req = 2'b00;
        wait_rsp(cnt);
        checks++;
        if (!ok || cnt != 6 || arb.rsp_err !== 1'b0 || arb.rsp_state !== perm_model(IV)) begin
            errors++;
            $display("FAIL wdog_recover: cycles=%0d err=%b state=%h, want 6 0 %h",
                     cnt, arb.rsp_err, arb.rsp_state, perm_model(IV));
        end
        ack();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        bit ok;
        int cnt;
        model_delay = 3;
        arb.req_rounds_b = 2'b10;
        arb.req = 2'b10;
        wait_gnt(ok);
        checks++;
        if (!ok || arb.gnt !== 2'b10 || arb.perm_nrounds !== 4'd6) begin
            errors++;
            $display("FAIL bp_gnt: gnt=%b nrounds=%0d, want 10 6", arb.gnt, arb.perm_nrounds);
        end
        arb.req = 2'b00;
        wait_rsp(cnt);
        held = arb.rsp_state;
        checks++;
        if (held !== perm_model(ST1)) begin
            errors++;
            $display("FAIL bp_rsp: state=%h, want %h", held, perm_model(ST1));
        end
        arb.rsp_ready = 2'b01;
        arb.req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (arb.rsp_valid !== 2'b10 || arb.rsp_state !== held || arb.gnt !== 2'b00 ||
                arb.busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b gnt=%b busy=%b state_ok=%0d, want 10 00 1 1",
                         i, arb.rsp_valid, arb.gnt, arb.busy, arb.rsp_state === held);
            end
        end
        arb.rsp_ready = 2'b10;
        tick();
        arb.rsp_ready = 2'b00;
        checks++;
        if (arb.rsp_valid !== 2'b00 || arb.busy !== 1'b0 || arb.gnt !== 2'b00) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b gnt=%b, want 00 0 00",
                     arb.rsp_valid, arb.busy, arb.gnt);
        end
        tick();
        checks++;
        if (arb.gnt !== 2'b01) begin
            errors++;
            $display("FAIL bp_pending_gnt: gnt=%b, want 01", arb.gnt);
        end
        arb.req = 2'b00;
        wait_rsp(cnt);
        ack();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int cnt;
        model_delay = 20;
        arb.req = 2'b10;
        wait_gnt(ok);
        arb.req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (arb.gnt !== '0 || arb.rsp_valid !== '0 || arb.busy !== 1'b0 || arb.perm_start !== 1'b0 ||
            arb.perm_in !== '0 || arb.perm_nrounds !== 4'd0 || arb.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_clear: gnt=%b valid=%b busy=%b start=%b nrounds=%0d err=%b",
                     arb.gnt, arb.rsp_valid, arb.busy, arb.perm_start, arb.perm_nrounds, arb.rsp_err);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (arb.rsp_valid !== 2'b00 || arb.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_late%0d: valid=%b busy=%b, want 00 0",
                         i, arb.rsp_valid, arb.busy);
            end
        end
        model_delay = 4;
        arb.req = 2'b11;
        wait_gnt(ok);
        checks++;
        if (!ok || arb.gnt !== 2'b01) begin
            errors++;
            $display("FAIL rst_wait_ptr: gnt=%b, want 01", arb.gnt);
        end
        wait_rsp(cnt);
        ack();
        wait_gnt(ok);
        arb.req = 2'b00;
        checks++;
        if (!ok || arb.gnt !== 2'b10) begin
            errors++;
            $display("FAIL rst_wait_req1: gnt=%b, want 10", arb.gnt);
        end
        wait_rsp(cnt);
        checks++;
        if (cnt != 5 || arb.rsp_valid !== 2'b10 || arb.rsp_state !== perm_model(ST1)) begin
            errors++;
            $display("FAIL rst_wait_rsp1: cycles=%0d valid=%b state=%h, want 5 10 %h",
                     cnt, arb.rsp_valid, arb.rsp_state, perm_model(ST1));
        end
        ack();
    endtask

    task automatic test_done_on_timeout();
        bit ok;
        int cnt;
        model_delay = 63;
        arb.req = 2'b01;
        wait_gnt(ok);
        arb.req = 2'b00;
        wait_rsp(cnt);
        checks++;
        if (!ok || cnt != 64 || arb.rsp_valid !== 2'b01 || arb.rsp_err !== 1'b0 ||
            arb.rsp_state !== perm_model(IV)) begin
            errors++;
            $display("FAIL done_at_timeout: cycles=%0d valid=%b err=%b state=%h, want 64 01 0 %h",
                     cnt, arb.rsp_valid, arb.rsp_err, arb.rsp_state, perm_model(IV));
        end
        ack();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        arb.req          = '0;
        arb.req_rounds_b = '0;
        arb.req_state    = '0;
        arb.rsp_ready    = '0;
        test_reset();
        test_single();
        test_contention();
        test_watchdog();
        test_backpressure();
        test_reset_mid_wait();
        test_done_on_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
